// File: rtl/rtc_pkg.sv
// Shared definitions for the rtc load/adjust controller: register map,
// CTRL/STATUS bit positions, command FSM encoding and field widths.
package rtc_pkg;

  localparam int NS_W  = 38;
  localparam int SEC_W = 48;
  localparam int PER_W = 40;

  localparam int unsigned A_CTRL      = 'h00;
  localparam int unsigned A_STATUS    = 'h04;
  localparam int unsigned A_PERIOD_HI = 'h08;
  localparam int unsigned A_PERIOD_LO = 'h0C;
  localparam int unsigned A_ADJ_HI    = 'h10;
  localparam int unsigned A_ADJ_LO    = 'h14;
  localparam int unsigned A_ADJ_CNT   = 'h18;
  localparam int unsigned A_SEC_HI    = 'h20;
  localparam int unsigned A_SEC_LO    = 'h24;
  localparam int unsigned A_NS        = 'h28;
  localparam int unsigned A_NS_FRAC   = 'h2C;

  localparam int CTRL_GET    = 0;
  localparam int CTRL_TIME   = 1;
  localparam int CTRL_PERIOD = 2;
  localparam int CTRL_ADJ    = 3;

  localparam int ST_ADJ_DONE = 0;
  localparam int ST_BUSY     = 1;
  localparam int ST_PPS      = 2;

  // State value k+1 services CTRL bit k, so a state value doubles as the
  // index of the first command bit still to be considered after it.
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_GET    = 3'd1,
    S_TIME   = 3'd2,
    S_PERIOD = 3'd3,
    S_ADJ    = 3'd4
  } state_e;

  function automatic state_e next_cmd_state(input logic [3:0] pend, input logic [2:0] from);
    logic [3:0] m;
    state_e     s;
    m = pend & (4'hF << from);
    if      (m[CTRL_GET])    s = S_GET;
    else if (m[CTRL_TIME])   s = S_TIME;
    else if (m[CTRL_PERIOD]) s = S_PERIOD;
    else if (m[CTRL_ADJ])    s = S_ADJ;
    else                     s = S_IDLE;
    return s;
  endfunction

endpackage

// File: rtl/rtc_ctrl_fsm.sv
// Command sequencer: walks GET -> TIME -> PERIOD -> ADJ one state per cycle,
// skipping commands that were not requested, and decodes one strobe per state.
module rtc_ctrl_fsm
  import rtc_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_cmd_wr,
  input  logic [3:0] i_cmd,
  output logic       o_busy,
  output logic       o_snap_en,
  output logic       o_time_ld,
  output logic       o_period_ld,
  output logic       o_adj_ld
);

  state_e     r_state;
  state_e     w_state_nxt;
  logic [3:0] r_pend;
  logic [3:0] w_pend_nxt;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // its next value from the same pre-edge snapshot of the logic.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_pend  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_pend  <= w_pend_nxt;
    end
  end

  // NOTE: every output of this block gets a default first, so no path through
  // the case leaves a signal unassigned and no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    w_pend_nxt  = r_pend;
    o_snap_en   = 1'b0;
    o_time_ld   = 1'b0;
    o_period_ld = 1'b0;
    o_adj_ld    = 1'b0;

    if (r_state == S_IDLE) begin
      if (i_cmd_wr && (|i_cmd)) begin
        w_pend_nxt  = i_cmd;
        w_state_nxt = next_cmd_state(i_cmd, 3'd0);
      end
    end else begin
      w_state_nxt = next_cmd_state(r_pend, r_state);
      if (w_state_nxt == S_IDLE) w_pend_nxt = '0;
    end

    case (r_state)
      S_GET:    o_snap_en   = 1'b1;
      S_TIME:   o_time_ld   = 1'b1;
      S_PERIOD: o_period_ld = 1'b1;
      S_ADJ:    o_adj_ld    = 1'b1;
      default:  ;
    endcase
  end

  assign o_busy = (r_state != S_IDLE);

endmodule

// File: rtl/rtc_ctrl.sv
// Host register file and initiator for the rtc load/adjust interface.
// Optional PPS interrupt enabled by defining RTC_CTRL_PPS_IRQ_EN.
module rtc_ctrl
  import rtc_pkg::*;
#(
  parameter int          ADDR_W     = 8,
  parameter logic [39:0] PERIOD_RST = 40'h0A00000000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_in,
  input  logic              rd_in,
  input  logic [ADDR_W-1:0] addr_in,
  input  logic [31:0]       data_in,
  output logic [31:0]       data_out,
  output logic              rd_ack,
  output logic              time_ld,
  output logic [37:0]       time_reg_ns_in,
  output logic [47:0]       time_reg_sec_in,
  output logic              period_ld,
  output logic [39:0]       period_in,
  output logic              adj_ld,
  output logic [31:0]       adj_ld_data,
  output logic [39:0]       period_adj,
  input  logic              adj_ld_done,
  input  logic [37:0]       time_reg_ns,
  input  logic [47:0]       time_reg_sec,
  input  logic              time_one_pps,
  output logic              irq
);

  logic [PER_W-1:0] r_period;
  logic [PER_W-1:0] r_adj;
  logic [31:0]      r_adj_cnt;
  logic [SEC_W-1:0] r_tod_sec;
  logic [NS_W-1:0]  r_tod_ns;
  logic [SEC_W-1:0] r_snap_sec;
  logic [NS_W-1:0]  r_snap_ns;
  logic [31:0]      r_data_out;
  logic             r_rd_ack;
  logic [31:0]      w_rd_data;
  logic             w_busy;
  logic             w_snap_en;
  logic             w_wr_ok;
  logic             w_cmd_wr;
  logic             w_pps_flag;

  // Staging only moves while idle, which keeps strobe data stable.
  assign w_wr_ok  = wr_in & ~w_busy;
  assign w_cmd_wr = w_wr_ok && (addr_in == ADDR_W'(A_CTRL));

  rtc_ctrl_fsm u_fsm (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_cmd_wr    (w_cmd_wr),
    .i_cmd       (data_in[3:0]),
    .o_busy      (w_busy),
    .o_snap_en   (w_snap_en),
    .o_time_ld   (time_ld),
    .o_period_ld (period_ld),
    .o_adj_ld    (adj_ld)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_period  <= PERIOD_RST;
      r_adj     <= '0;
      r_adj_cnt <= 32'hFFFF_FFFF;
      r_tod_sec <= '0;
      r_tod_ns  <= '0;
    end else if (w_wr_ok) begin
      case (addr_in)
        ADDR_W'(A_PERIOD_HI): r_period[39:32]  <= data_in[7:0];
        ADDR_W'(A_PERIOD_LO): r_period[31:0]   <= data_in;
        ADDR_W'(A_ADJ_HI):    r_adj[39:32]     <= data_in[7:0];
        ADDR_W'(A_ADJ_LO):    r_adj[31:0]      <= data_in;
        ADDR_W'(A_ADJ_CNT):   r_adj_cnt        <= data_in;
        ADDR_W'(A_SEC_HI):    r_tod_sec[47:32] <= data_in[15:0];
        ADDR_W'(A_SEC_LO):    r_tod_sec[31:0]  <= data_in;
        ADDR_W'(A_NS):        r_tod_ns[37:8]   <= data_in[29:0];
        ADDR_W'(A_NS_FRAC):   r_tod_ns[7:0]    <= data_in[7:0];
        default: ;
      endcase
    end
  end

  // Both halves are captured on the same edge, so seconds and ns always agree.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_snap_sec <= '0;
      r_snap_ns  <= '0;
    end else if (w_snap_en) begin
      r_snap_sec <= time_reg_sec;
      r_snap_ns  <= time_reg_ns;
    end
  end

`ifdef RTC_CTRL_PPS_IRQ_EN
  logic r_pps_flag;

  // Set has priority over the W1C clear so a pulse is never lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_pps_flag <= 1'b0;
    else if (time_one_pps)
      r_pps_flag <= 1'b1;
    else if (wr_in && (addr_in == ADDR_W'(A_STATUS)) && data_in[ST_PPS])
      r_pps_flag <= 1'b0;
  end

  assign w_pps_flag = r_pps_flag;
`else
  logic w_unused_pps;
  assign w_unused_pps = time_one_pps;
  assign w_pps_flag   = 1'b0;
`endif

  always_comb begin
    w_rd_data = '0;
    case (addr_in)
      ADDR_W'(A_STATUS): begin
        w_rd_data[ST_ADJ_DONE] = adj_ld_done;
        w_rd_data[ST_BUSY]     = w_busy;
        w_rd_data[ST_PPS]      = w_pps_flag;
      end
      ADDR_W'(A_PERIOD_HI): w_rd_data[7:0]  = r_period[39:32];
      ADDR_W'(A_PERIOD_LO): w_rd_data       = r_period[31:0];
      ADDR_W'(A_ADJ_HI):    w_rd_data[7:0]  = r_adj[39:32];
      ADDR_W'(A_ADJ_LO):    w_rd_data       = r_adj[31:0];
      ADDR_W'(A_ADJ_CNT):   w_rd_data       = r_adj_cnt;
      ADDR_W'(A_SEC_HI):    w_rd_data[15:0] = r_snap_sec[47:32];
      ADDR_W'(A_SEC_LO):    w_rd_data       = r_snap_sec[31:0];
      ADDR_W'(A_NS):        w_rd_data[29:0] = r_snap_ns[37:8];
      ADDR_W'(A_NS_FRAC):   w_rd_data[7:0]  = r_snap_ns[7:0];
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_ack   <= 1'b0;
      r_data_out <= '0;
    end else begin
      r_rd_ack <= rd_in;
      if (rd_in) r_data_out <= w_rd_data;
    end
  end

  assign data_out        = r_data_out;
  assign rd_ack          = r_rd_ack;
  assign time_reg_ns_in  = r_tod_ns;
  assign time_reg_sec_in = r_tod_sec;
  assign period_in       = r_period;
  assign period_adj      = r_adj;
  assign adj_ld_data     = r_adj_cnt;
  assign irq             = w_pps_flag;

endmodule

// File: tb/tb_rtc_ctrl.sv
// Directed bench for rtc_ctrl: register reset values, command sequencing,
// busy write-drop, snapshot coherence, reset abort and the PPS interrupt.
module tb_rtc_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wr_in = 1'b0;
  logic        rd_in = 1'b0;
  logic [7:0]  addr_in = '0;
  logic [31:0] data_in = '0;
  logic [31:0] data_out;
  logic        rd_ack;
  logic        time_ld;
  logic [37:0] time_reg_ns_in;
  logic [47:0] time_reg_sec_in;
  logic        period_ld;
  logic [39:0] period_in;
  logic        adj_ld;
  logic [31:0] adj_ld_data;
  logic [39:0] period_adj;
  logic        adj_ld_done = 1'b1;
  logic [37:0] time_reg_ns;
  logic [47:0] time_reg_sec;
  logic        time_one_pps = 1'b0;
  logic        irq;

  int checks = 0;
  int errors = 0;

  // Simple rtc model: advances 10 ns per cycle and wraps at one second.
  logic        rtc_load = 1'b0;
  logic        rtc_run  = 1'b0;
  int unsigned ld_ns  = 0;
  int unsigned ld_sec = 0;
  int unsigned m_ns   = 0;
  int unsigned m_sec  = 0;

  int n_time   = 0;
  int n_period = 0;
  int n_adj    = 0;

  rtc_ctrl dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .wr_in           (wr_in),
    .rd_in           (rd_in),
    .addr_in         (addr_in),
    .data_in         (data_in),
    .data_out        (data_out),
    .rd_ack          (rd_ack),
    .time_ld         (time_ld),
    .time_reg_ns_in  (time_reg_ns_in),
    .time_reg_sec_in (time_reg_sec_in),
    .period_ld       (period_ld),
    .period_in       (period_in),
    .adj_ld          (adj_ld),
    .adj_ld_data     (adj_ld_data),
    .period_adj      (period_adj),
    .adj_ld_done     (adj_ld_done),
    .time_reg_ns     (time_reg_ns),
    .time_reg_sec    (time_reg_sec),
    .time_one_pps    (time_one_pps),
    .irq             (irq)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rtc_load) begin
      m_ns  <= ld_ns;
      m_sec <= ld_sec;
    end else if (rtc_run) begin
      if (m_ns + 10 >= 1000000000) begin
        m_ns  <= m_ns + 10 - 1000000000;
        m_sec <= m_sec + 1;
      end else begin
        m_ns <= m_ns + 10;
      end
    end
  end

  assign time_reg_ns  = {m_ns[29:0], 8'h00};
  assign time_reg_sec = {16'h0000, m_sec};

  always @(posedge clk) begin
    if (time_ld)   n_time   <= n_time + 1;
    if (period_ld) n_period <= n_period + 1;
    if (adj_ld)    n_adj    <= n_adj + 1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  // Called at a negedge; returns at the next negedge, one edge after sampling.
  task automatic bus_write(input logic [7:0] a, input logic [31:0] d);
    wr_in   = 1'b1;
    addr_in = a;
    data_in = d;
    @(negedge clk);
    wr_in   = 1'b0;
    data_in = '0;
  endtask

  task automatic bus_read(input logic [7:0] a, output logic [31:0] d, output logic ack);
    rd_in   = 1'b1;
    addr_in = a;
    @(negedge clk);
    rd_in = 1'b0;
    d     = data_out;
    ack   = rd_ack;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    logic        ack;
    checks++;
    if ({time_ld, period_ld, adj_ld, rd_ack, irq} !== 5'b0) begin
      errors++;
      $display("FAIL reset_strobes: got %b exp 00000", {time_ld, period_ld, adj_ld, rd_ack, irq});
    end
    checks++;
    if (period_in !== 40'h0A00000000) begin
      errors++;
      $display("FAIL reset_period_in: got %h exp 0a00000000", period_in);
    end
    checks++;
    if (adj_ld_data !== 32'hFFFFFFFF) begin
      errors++;
      $display("FAIL reset_adj_cnt_out: got %h exp ffffffff", adj_ld_data);
    end
    rst_n = 1'b1;
    @(negedge clk);
    bus_read(8'h0C, d, ack);
    checks++;
    if (ack !== 1'b1) begin
      errors++;
      $display("FAIL rd_ack_latency: got %b exp 1", ack);
    end
    checks++;
    if (d !== 32'h0) begin
      errors++;
      $display("FAIL reset_period_lo: got %h exp 00000000", d);
    end
    @(negedge clk);
    checks++;
    if (rd_ack !== 1'b0) begin
      errors++;
      $display("FAIL rd_ack_single: got %b exp 0", rd_ack);
    end
    bus_read(8'h08, d, ack);
    checks++;
    if (d !== 32'h0000000A) begin
      errors++;
      $display("FAIL reset_period_hi: got %h exp 0000000a", d);
    end
    bus_read(8'h18, d, ack);
    checks++;
    if (d !== 32'hFFFFFFFF) begin
      errors++;
      $display("FAIL reset_adj_cnt: got %h exp ffffffff", d);
    end
    bus_read(8'h04, d, ack);
    checks++;
    if (d !== 32'h00000001) begin
      errors++;
      $display("FAIL reset_status: got %h exp 00000001", d);
    end
    bus_read(8'h24, d, ack);
    checks++;
    if (d !== 32'h0) begin
      errors++;
      $display("FAIL reset_snapshot: got %h exp 00000000", d);
    end
  endtask

  task automatic test_time_set();
    logic [37:0] exp_ns;
    int          t0;
    exp_ns = {30'd999999990, 8'h80};
    bus_write(8'h24, 32'd5);
    bus_write(8'h28, 32'd999999990);
    bus_write(8'h2C, 32'h80);
    t0 = n_time;
    bus_write(8'h00, 32'h2);
    checks++;
    if ({time_ld, period_ld, adj_ld} !== 3'b100) begin
      errors++;
      $display("FAIL time_set_strobe: got %b exp 100", {time_ld, period_ld, adj_ld});
    end
    checks++;
    if (time_reg_sec_in !== 48'd5) begin
      errors++;
      $display("FAIL time_set_sec: got %0d exp 5", time_reg_sec_in);
    end
    checks++;
    if (time_reg_ns_in !== exp_ns) begin
      errors++;
      $display("FAIL time_set_ns: got %h exp %h", time_reg_ns_in, exp_ns);
    end
    @(negedge clk);
    checks++;
    if (time_ld !== 1'b0 || n_time !== t0 + 1) begin
      errors++;
      $display("FAIL time_set_single: time_ld %b count %0d exp 0 and %0d", time_ld, n_time - t0, 1);
    end
  endtask

  task automatic test_combined();
    logic [2:0] exp_stb;
    logic       exp_busy;
    bus_write(8'h0C, 32'h80000000);
    bus_write(8'h18, 32'd100);
    bus_write(8'h10, 32'h1);
    bus_write(8'h00, 32'hF);
    rd_in   = 1'b1;
    addr_in = 8'h04;
    // k counts cycles after the command write; data_out shows busy of cycle k-1.
    for (int k = 1; k <= 6; k++) begin
      exp_stb = (k == 2) ? 3'b100 : (k == 3) ? 3'b010 : (k == 4) ? 3'b001 : 3'b000;
      checks++;
      if ({time_ld, period_ld, adj_ld} !== exp_stb) begin
        errors++;
        $display("FAIL combined_strobe_k%0d: got %b exp %b", k, {time_ld, period_ld, adj_ld}, exp_stb);
      end
      if (k > 1) begin
        exp_busy = (k - 1 <= 4);
        checks++;
        if (data_out[1] !== exp_busy) begin
          errors++;
          $display("FAIL combined_busy_k%0d: got %b exp %b", k - 1, data_out[1], exp_busy);
        end
      end
      if (k == 3) begin
        checks++;
        if (period_in !== 40'h0A80000000) begin
          errors++;
          $display("FAIL combined_period_in: got %h exp 0a80000000", period_in);
        end
      end
      if (k == 4) begin
        checks++;
        if (adj_ld_data !== 32'd100 || period_adj !== 40'h0100000000) begin
          errors++;
          $display("FAIL combined_adj_data: got %h/%h exp 00000064/0100000000", adj_ld_data, period_adj);
        end
      end
      @(negedge clk);
    end
    rd_in = 1'b0;
  endtask

  task automatic test_busy_drop();
    int t0, p0, a0;
    t0 = n_time;
    p0 = n_period;
    a0 = n_adj;
    bus_write(8'h00, 32'h2);
    bus_write(8'h28, 32'd7);
    checks++;
    if (time_reg_ns_in[37:8] !== 30'd999999990) begin
      errors++;
      $display("FAIL busy_ns_drop: got %0d exp 999999990", time_reg_ns_in[37:8]);
    end
    bus_write(8'h00, 32'h4);
    bus_write(8'h00, 32'h8);
    repeat (4) @(negedge clk);
    checks++;
    if (n_time !== t0 + 1 || n_period !== p0 + 1 || n_adj !== a0) begin
      errors++;
      $display("FAIL busy_ctrl_drop: strobes t/p/a got %0d/%0d/%0d exp 1/1/0",
               n_time - t0, n_period - p0, n_adj - a0);
    end
  endtask

  task automatic test_snapshot();
    logic [31:0] d_sec, d_ns, d_ns2, d_hi, d_frac;
    logic        ack, ok;
    ld_ns    = 999999996;
    ld_sec   = 10;
    rtc_load = 1'b1;
    @(negedge clk);
    rtc_load = 1'b0;
    rtc_run  = 1'b1;
    bus_write(8'h00, 32'h1);
    @(negedge clk);
    bus_read(8'h24, d_sec, ack);
    bus_read(8'h28, d_ns, ack);
    bus_read(8'h20, d_hi, ack);
    bus_read(8'h2C, d_frac, ack);
    ok = (d_sec == 32'd10 && d_ns >= 32'd999999990 && d_ns < 32'd1000000000) ||
         (d_sec == 32'd11 && d_ns <= 32'd30);
    checks++;
    if (ok !== 1'b1) begin
      errors++;
      $display("FAIL snapshot_coherent: got sec %0d ns %0d exp (10,~999999996) or (11,small)", d_sec, d_ns);
    end
    checks++;
    if (d_hi !== 32'h0 || d_frac !== 32'h0) begin
      errors++;
      $display("FAIL snapshot_hi_frac: got %h/%h exp 0/0", d_hi, d_frac);
    end
    repeat (5) @(negedge clk);
    bus_read(8'h28, d_ns2, ack);
    checks++;
    if (d_ns2 !== d_ns) begin
      errors++;
      $display("FAIL snapshot_stable: got %0d exp %0d", d_ns2, d_ns);
    end
    rtc_run = 1'b0;
  endtask

  task automatic test_reset_abort();
    logic [31:0] d;
    logic        ack;
    int          t0, p0, a0;
    bus_write(8'h00, 32'hE);
    rst_n = 1'b0;
    #1;
    t0 = n_time;
    p0 = n_period;
    a0 = n_adj;
    checks++;
    if ({time_ld, period_ld, adj_ld} !== 3'b000) begin
      errors++;
      $display("FAIL abort_async: got %b exp 000", {time_ld, period_ld, adj_ld});
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    checks++;
    if (n_time !== t0 || n_period !== p0 || n_adj !== a0) begin
      errors++;
      $display("FAIL abort_no_strobe: t/p/a got %0d/%0d/%0d exp 0/0/0", n_time - t0, n_period - p0, n_adj - a0);
    end
    bus_read(8'h04, d, ack);
    checks++;
    if (d !== 32'h1) begin
      errors++;
      $display("FAIL abort_status: got %h exp 00000001", d);
    end
  endtask

  task automatic test_pps();
    logic [31:0] d;
    logic        ack;
    time_one_pps = 1'b1;
    @(negedge clk);
    time_one_pps = 1'b0;
`ifdef RTC_CTRL_PPS_IRQ_EN
    checks++;
    if (irq !== 1'b1) begin
      errors++;
      $display("FAIL pps_set: got %b exp 1", irq);
    end
    bus_read(8'h04, d, ack);
    checks++;
    if (d !== 32'h5) begin
      errors++;
      $display("FAIL pps_status: got %h exp 00000005", d);
    end
    bus_write(8'h04, 32'h4);
    checks++;
    if (irq !== 1'b0) begin
      errors++;
      $display("FAIL pps_clear: got %b exp 0", irq);
    end
    time_one_pps = 1'b1;
    @(negedge clk);
    time_one_pps = 1'b1;
    bus_write(8'h04, 32'h4);
    time_one_pps = 1'b0;
    checks++;
    if (irq !== 1'b1) begin
      errors++;
      $display("FAIL pps_set_wins: got %b exp 1", irq);
    end
`else
    checks++;
    if (irq !== 1'b0) begin
      errors++;
      $display("FAIL pps_irq_off: got %b exp 0", irq);
    end
    bus_write(8'h04, 32'h4);
    bus_read(8'h04, d, ack);
    checks++;
    if (d !== 32'h1) begin
      errors++;
      $display("FAIL pps_status_off: got %h exp 00000001", d);
    end
`endif
  endtask

  initial begin
    repeat (3) @(negedge clk);
    test_reset();
    test_time_set();
    test_combined();
    test_busy_drop();
    test_snapshot();
    test_reset_abort();
    test_pps();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rtc_ctrl.md
Name: rtc_ctrl

Overview:
- Register-bus controller that acts as the initiator on the rtc load/adjust interface.
- A host writes staging registers and issues commands. The block sequences single-cycle time_ld / period_ld / adj_ld strobes with stable data into the rtc.
- On command, it captures an atomic snapshot of the rtc time outputs for readback.
- Sits between the host bus bridge and the rtc instance in the ha1588 core.

Parameters:
ADDR_W, 8, bus address width (byte addresses, 32-bit registers)
PERIOD_RST, 40'h0A00000000, reset value of period staging register (10 ns)

Ports:
clk  in  1  system clock, same clock as rtc
rst_n  in  1  asynchronous active-low reset
wr_in  in  1  bus write strobe, one cycle
rd_in  in  1  bus read strobe, one cycle
addr_in  in  ADDR_W  register byte address
data_in  in  32  write data
data_out  out  32  read data, registered
rd_ack  out  1  read data valid, one cycle
time_ld  out  1  rtc ToD load strobe
time_reg_ns_in  out  38  ToD ns[37:8] and frac[7:0] to rtc
time_reg_sec_in  out  48  ToD seconds to rtc
period_ld  out  1  rtc period load strobe
period_in  out  40  period ns[39:32] and frac[31:0]
adj_ld  out  1  rtc adjust load strobe
adj_ld_data  out  32  adjust time mark (cycle count)
period_adj  out  40  temporary period delta
adj_ld_done  in  1  rtc adjust idle/done
time_reg_ns  in  38  live rtc ns
time_reg_sec  in  48  live rtc seconds
time_one_pps  in  1  rtc pps pulse
irq  out  1  pps interrupt (see Optional Feature)

Behaviour:
- Register map: all unlisted bits read 0; writes to RO/unmapped addresses are ignored.
  - 0x00 CTRL (W): b0 GET, b1 TIME_SET, b2 PERIOD_SET, b3 ADJ_SET. Command bits self-clear; CTRL reads 0.
  - 0x04 STATUS (R): b0 adj_ld_done, b1 busy, b2 pps_flag.
  - 0x08 PERIOD_HI [7:0], 0x0C PERIOD_LO [31:0].
  - 0x10 ADJ_HI [7:0], 0x14 ADJ_LO [31:0], 0x18 ADJ_CNT [31:0].
  - 0x20 SEC_HI [15:0], 0x24 SEC_LO [31:0], 0x28 NS [29:0], 0x2C NS_FRAC [7:0].
- Time registers 0x20–0x2C:
  - A write goes to the ToD staging register.
  - A read returns the snapshot register, not staging and not live time.
- Reads: data_out and rd_ack are valid exactly 1 cycle after rd_in. A simultaneous wr_in and rd_in is a write plus a read of the pre-write value.
- Command FSM:
  - States: IDLE, GET, TIME, PERIOD, ADJ.
  - In IDLE, a CTRL write with any set bit latches the pending bits and starts the sequence.
  - Fixed order, one state per cycle, skipping unset bits: GET → TIME → PERIOD → ADJ → IDLE.
- Per-state actions:
  - GET: copies time_reg_ns and time_reg_sec into the snapshot in a single cycle, so the snapshot is atomic.
  - TIME, PERIOD, ADJ: each asserts its strobe for exactly that one cycle.
  - busy = 1 in every state except IDLE.
- Latency: a CTRL write in cycle N with only TIME_SET set gives time_ld high in cycle N+1 and busy low in N+2.
- Strobe data: *_in data outputs are driven continuously from staging registers. Staging is frozen while busy, so data is stable for the whole strobe cycle.
- While busy, host writes to CTRL and to staging registers are dropped. Reads are always serviced.
- Reset values:
  - All strobes, rd_ack, data_out, irq, snapshot and time staging: 0.
  - period staging: PERIOD_RST.
  - adj staging: 0.
  - ADJ_CNT staging: 32'hFFFFFFFF, i.e. no pending mark.
  - FSM: IDLE.
- Reset mid-sequence aborts immediately. Pending commands are discarded, and no strobe fires after rst_n is released.

Optional Feature:
- Macro: RTC_CTRL_PPS_IRQ_EN.
- With the macro:
  - pps_flag sets on time_one_pps.
  - Writing STATUS with b2 = 1 clears pps_flag (W1C). If a set and a clear land in the same cycle, set wins.
  - irq = pps_flag, registered.
- Without the macro: irq is tied 0, STATUS b2 reads 0, and STATUS writes are ignored.

Decomposition:
- Package rtc_pkg holds:
  - register address constants;
  - CTRL/STATUS bit positions;
  - FSM state encoding;
  - width constants NS_W = 38, SEC_W = 48, PER_W = 40.
- One natural sub-module: rtc_ctrl_fsm (command sequencer producing the strobes, snapshot enable and busy). The register file stays in rtc_ctrl.

Test Plan:
- Read-after-reset:
  - read 0x0C → 0, 0x08 → 0x0A;
  - read 0x18 → 0xFFFFFFFF;
  - read 0x04 → b1 = 0;
  - rd_ack 1 cycle after rd_in.
- Time set: write SEC_LO = 5, NS = 999999990, NS_FRAC = 0x80, then CTRL = 0x2 → single-cycle time_ld with time_reg_sec_in = 5 and time_reg_ns_in = {999999990, 8'h80}.
- Combined command: CTRL = 0xF with PERIOD_LO = 0x80000000, ADJ_CNT = 100, ADJ_HI = 1 → GET, time_ld, period_ld, adj_ld on 4 consecutive cycles. Strobes never overlap, and busy lasts 4 cycles.
- Busy drop:
  - write NS = 7 one cycle after CTRL = 0x2 → dropped; the NS staging register keeps its old value;
  - a second CTRL write while busy → no extra strobe.
- Snapshot atomicity: rtc model with sec = 10 and ns at 999999996 about to wrap, then issue GET → snapshot is coherent, either (10, 999999996) or (11, small). SEC_LO and NS are read afterwards, and the ns read returns the snapshot regardless of the live value.
- With RTC_CTRL_PPS_IRQ_EN:
  - time_one_pps pulse → irq = 1 the next cycle;
  - write STATUS = 0x4 → irq = 0;
  - clear and pps in the same cycle → irq stays 1.
